// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one single-cycle ALU between two requesters.
// Each operation is captured, run through the ALU and returned with flags. Only one operation is in flight at a time.

module alu_share_alu #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 3
) (
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [OP_W-1:0]   op_i,
  output logic [DATA_W-1:0] result_o,
  output logic [4:0]        flags_o,
  output logic              err_o
);
  localparam logic [OP_W-1:0] OP_ADD = 3'b000;
  localparam logic [OP_W-1:0] OP_SUB = 3'b001;
  localparam logic [OP_W-1:0] OP_AND = 3'b010;
  localparam logic [OP_W-1:0] OP_OR  = 3'b011;
  localparam logic [OP_W-1:0] OP_SLT = 3'b101;

  logic              is_sub;
  logic [DATA_W-1:0] b_eff;
  logic [DATA_W:0]   sum;
  logic [DATA_W-1:0] diff;
  logic              lt;
  logic              carry;
  logic              ovf;
  logic              slt;

  always_comb begin
    is_sub   = (op_i == OP_SUB);
    b_eff    = is_sub ? ~b_i : b_i;
    sum      = {1'b0, a_i} + {1'b0, b_eff} + {{DATA_W{1'b0}}, is_sub};
    diff     = a_i - b_i;
    // Signed less-than: differing signs decide directly, otherwise the difference sign does.
    lt       = (a_i[DATA_W-1] ^ b_i[DATA_W-1]) ? a_i[DATA_W-1] : diff[DATA_W-1];
    result_o = '0;
    carry    = 1'b0;
    ovf      = 1'b0;
    slt      = 1'b0;
    err_o    = 1'b0;
    case (op_i)
      OP_ADD, OP_SUB: begin
        result_o = sum[DATA_W-1:0];
        carry    = sum[DATA_W];
        ovf      = (a_i[DATA_W-1] == b_eff[DATA_W-1]) && (sum[DATA_W-1] != a_i[DATA_W-1]);
      end
      OP_AND: result_o = a_i & b_i;
      OP_OR:  result_o = a_i | b_i;
      OP_SLT: begin
        result_o = {{(DATA_W-1){1'b0}}, lt};
        slt      = lt;
      end
      default: err_o = 1'b1;
    endcase
    flags_o = {slt, ovf, carry, result_o[DATA_W-1], (result_o == '0)};
  end
endmodule

module alu_share_arbiter #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [OP_W-1:0]   req0_op,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [OP_W-1:0]   req1_op,
  output logic              resp0_valid,
  input  logic              resp0_ready,
  output logic              resp1_valid,
  input  logic              resp1_ready,
  output logic [DATA_W-1:0] resp_result,
  output logic [4:0]        resp_flags,
  output logic              resp_err,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t            state_q;
  logic              rr_ptr_q;
  logic              owner_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [OP_W-1:0]   op_q;
  logic [DATA_W-1:0] result_q;
  logic [4:0]        flags_q;
  logic              err_q;
  logic              resp0_valid_q;
  logic              resp1_valid_q;

  logic              owner_d;
  logic              accept;
  logic              resp_hs;
  logic [DATA_W-1:0] alu_result;
  logic [4:0]        alu_flags;
  logic              alu_err;

  // Requester 1 wins when it is alone or when both ask and it holds priority.
  assign owner_d    = req1_valid & (~req0_valid | rr_ptr_q);
  assign accept     = (state_q == IDLE) & (req0_valid | req1_valid);
  assign req0_ready = (state_q == IDLE) & req0_valid & ~owner_d;
  assign req1_ready = (state_q == IDLE) & owner_d;
  assign resp_hs    = owner_q ? resp1_ready : resp0_ready;

  alu_share_alu #(.DATA_W(DATA_W), .OP_W(OP_W)) u_alu (
    .a_i      (a_q),
    .b_i      (b_q),
    .op_i     (op_q),
    .result_o (alu_result),
    .flags_o  (alu_flags),
    .err_o    (alu_err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      rr_ptr_q      <= 1'b0;
      owner_q       <= 1'b0;
      a_q           <= '0;
      b_q           <= '0;
      op_q          <= '0;
      result_q      <= '0;
      flags_q       <= '0;
      err_q         <= 1'b0;
      resp0_valid_q <= 1'b0;
      resp1_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            a_q     <= owner_d ? req1_a  : req0_a;
            b_q     <= owner_d ? req1_b  : req0_b;
            op_q    <= owner_d ? req1_op : req0_op;
            owner_q <= owner_d;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          result_q      <= alu_result;
          flags_q       <= alu_flags;
          err_q         <= alu_err;
          resp0_valid_q <= ~owner_q;
          resp1_valid_q <= owner_q;
          state_q       <= RESP;
        end
        RESP: begin
          // Priority flips to the other requester whether or not it is waiting.
          if (resp_hs) begin
            rr_ptr_q      <= ~owner_q;
            resp0_valid_q <= 1'b0;
            resp1_valid_q <= 1'b0;
            state_q       <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign resp0_valid = resp0_valid_q;
  assign resp1_valid = resp1_valid_q;
  assign resp_result = result_q;
  assign resp_flags  = flags_q;
  assign resp_err    = err_q;
  assign busy        = (state_q != IDLE);
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: reference model with per-cycle compare plus directed scenarios.

module tb_alu_share_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0]  req0_op, req1_op;
  logic        resp0_valid, resp1_valid, resp0_ready, resp1_ready;
  logic [31:0] resp_result;
  logic [4:0]  resp_flags;
  logic        resp_err, busy;

  int chk_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  alu_share_arbiter #(.DATA_W(32), .OP_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
    .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
    .resp_result(resp_result), .resp_flags(resp_flags), .resp_err(resp_err), .busy(busy)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  // {err, slt, ovf, carry, neg, zero, result} from plain integer arithmetic.
  function automatic logic [37:0] alu_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic        c, v, s, e;
    longint      sa, sb, t;
    r = '0; c = 0; v = 0; s = 0; e = 0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      3'd0: begin
        t = sa + sb; r = a + b;
        c = ({32'd0, a} + {32'd0, b}) > 64'hFFFF_FFFF;
        v = (t > SMAX) || (t < SMIN);
      end
      3'd1: begin
        t = sa - sb; r = a - b;
        c = (a >= b);
        v = (t > SMAX) || (t < SMIN);
      end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd5: begin s = (sa < sb); r = {31'd0, s}; end
      default: e = 1;
    endcase
    return {e, s, v, c, r[31], (r == 32'd0), r};
  endfunction

  int          m_phase;
  logic        m_ptr, m_owner;
  logic [37:0] m_res;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0; m_ptr = 0; m_owner = 0;
    end else begin
      case (m_phase)
        0: if (req0_valid || req1_valid) begin
             m_owner = req1_valid && (!req0_valid || m_ptr);
             m_res   = m_owner ? alu_model(req1_op, req1_a, req1_b) : alu_model(req0_op, req0_a, req0_b);
             m_phase = 1;
           end
        1: m_phase = 2;
        default: if (m_owner ? resp1_ready : resp0_ready) begin
             m_phase = 0;
             m_ptr   = !m_owner;
           end
      endcase
    end
  end

  always @(negedge clk) begin
    logic g1;
    if (!rst_n) begin
      check("rst_rdy0", req0_ready, 0);
      check("rst_rdy1", req1_ready, 0);
      check("rst_rsp0", resp0_valid, 0);
      check("rst_rsp1", resp1_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_result", resp_result, 0);
      check("rst_flags", resp_flags, 0);
      check("rst_err", resp_err, 0);
    end else begin
      g1 = req1_valid && (!req0_valid || m_ptr);
      check("rdy0", req0_ready, (m_phase == 0) && req0_valid && !g1);
      check("rdy1", req1_ready, (m_phase == 0) && g1);
      check("busy", busy, m_phase != 0);
      check("rsp0", resp0_valid, (m_phase == 2) && !m_owner);
      check("rsp1", resp1_valid, (m_phase == 2) && m_owner);
      if (m_phase == 2) begin
        check("result", resp_result, m_res[31:0]);
        check("flags", resp_flags, m_res[36:32]);
        check("err", resp_err, m_res[37]);
      end
    end
  end

  int dut_g[$];
  always @(posedge clk) begin
    if (rst_n) begin
      if (req0_valid && req0_ready) dut_g.push_back(0);
      if (req1_valid && req1_ready) dut_g.push_back(1);
    end
  end

  task automatic tick();
    logic s0, s1;
    @(posedge clk);
    s0 = req0_valid && req0_ready;
    s1 = req1_valid && req1_ready;
    #1;
    if (s0) req0_valid = 0;
    if (s1) req1_valid = 0;
  endtask

  task automatic set0(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    req0_op = op; req0_a = a; req0_b = b; req0_valid = 1;
  endtask

  task automatic set1(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    req1_op = op; req1_a = a; req1_b = b; req1_valid = 1;
  endtask

  task automatic do_reset();
    rst_n = 0;
    @(posedge clk);
    #1 rst_n = 1;
  endtask

  task automatic wait_resp(input logic who, input string tag);
    logic ok;
    ok = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      @(negedge clk);
      if ((who ? resp1_valid : resp0_valid) === 1'b1) begin ok = 1; break; end
    end
    if (!ok) check({tag, "_timeout"}, 0, 1);
  endtask

  task automatic check_resp(input string tag, input logic [31:0] r, input logic [4:0] f, input logic e);
    check({tag, "_result"}, resp_result, r);
    check({tag, "_flags"}, resp_flags, f);
    check({tag, "_err"}, resp_err, e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int n;
    req0_valid = 0; req1_valid = 0;
    req0_a = 0; req0_b = 0; req0_op = 0;
    req1_a = 0; req1_b = 0; req1_op = 0;
    resp0_ready = 1; resp1_ready = 1;
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;

    // Single add, latency T -> T+2
    set0(3'd0, 32'd5, 32'd7);
    @(negedge clk);
    check("t1_rdy0", req0_ready, 1);
    tick();
    @(negedge clk);
    check("t1_lat1", resp0_valid, 0);
    tick();
    @(negedge clk);
    check("t1_lat2", resp0_valid, 1);
    check_resp("t1", 32'd12, 5'b00000, 0);

    // Both valid after reset: req0 first
    tick();
    do_reset();
    set0(3'd1, 32'd3, 32'd3);
    set1(3'd3, 32'hF0, 32'h0F);
    @(negedge clk);
    check("t2_rdy0", req0_ready, 1);
    check("t2_rdy1", req1_ready, 0);
    wait_resp(0, "t2a");
    check_resp("t2a", 32'd0, 5'b00101, 0);
    wait_resp(1, "t2b");
    check_resp("t2b", 32'hFF, 5'b00000, 0);

    // Continuous contention: grants alternate
    tick();
    do_reset();
    base = dut_g.size();
    for (int i = 0; i < 40 && dut_g.size() < base + 6; i++) begin
      if (!req0_valid) set0(3'd0, i, 32'd1);
      if (!req1_valid) set1(3'd2, 32'hFFFF_0000 + i, 32'h0000_FFFF);
      tick();
    end
    req0_valid = 0; req1_valid = 0;
    repeat (4) tick();
    n = dut_g.size() - base;
    check("t3_count", n, 6);
    for (int k = 0; k < n && k < 6; k++)
      check($sformatf("t3_grant%0d", k), dut_g[base + k], k % 2);

    // Overflow add and signed slt
    set0(3'd0, 32'h7FFF_FFFF, 32'd1);
    wait_resp(0, "t4a");
    check_resp("t4a", 32'h8000_0000, 5'b01010, 0);
    set0(3'd5, 32'hFFFF_FFFF, 32'd1);
    wait_resp(0, "t4b");
    check_resp("t4b", 32'd1, 5'b10000, 0);

    // Back-pressure on resp1 for 10 cycles while req0 waits
    resp1_ready = 0;
    set0(3'd0, 32'd10, 32'd20);
    set1(3'd0, 32'd1, 32'd2);
    wait_resp(1, "t5");
    for (int i = 0; i < 10; i++) begin
      tick();
      @(negedge clk);
      check("t5_rsp1", resp1_valid, 1);
      check("t5_rsp0", resp0_valid, 0);
      check("t5_rdy0", req0_ready, 0);
      check("t5_busy", busy, 1);
      check("t5_result", resp_result, 32'd3);
    end
    resp1_ready = 1;
    wait_resp(0, "t5b");
    check_resp("t5b", 32'd30, 5'b00000, 0);

    // Illegal opcode
    set0(3'b110, 32'd1, 32'd2);
    wait_resp(0, "t6a");
    check_resp("t6a", 32'd0, 5'b00001, 1);

    // Reset during EXEC drops the op; arbitration restarts at req0
    set1(3'd0, 32'd4, 32'd4);
    tick();
    @(negedge clk);
    check("t6_rdy1", req1_ready, 1);
    tick();
    rst_n = 0;
    #2 rst_n = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t6_norsp1", resp1_valid, 0);
      check("t6_idle", busy, 0);
      tick();
    end
    set0(3'd0, 32'd9, 32'd9);
    set1(3'd0, 32'd1, 32'd1);
    @(negedge clk);
    check("t6_rdy0", req0_ready, 1);
    check("t6_rdy1n", req1_ready, 0);
    wait_resp(0, "t6b");
    check_resp("t6b", 32'd18, 5'b00000, 0);
    wait_resp(1, "t6c");
    check_resp("t6c", 32'd2, 5'b00000, 0);
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
    $finish;
  end
endmodule
